// File: rtl/regarb_defs.sv
// Shared definitions for the register-bank arbiter.
// Contents: FSM state encoding, default sizing constants and a constant
// clog2 helper used to size the requester-id field.
package regarb_defs;

   localparam int NREQ_DEF = 4;
   localparam int AW_DEF   = 3;
   localparam int DW_DEF   = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } regarb_state_e;

   // Number of bits needed to encode n distinct values (n >= 2).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >>> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/regbank.sv
// regbank: 2**AW x DW flip-flop storage with one write port and one
// registered read port. The whole array and the read register are cleared
// by the synchronous active-low reset.
// Ports:
//   clk     in   rising-edge clock
//   reset_n in   synchronous active-low clear
//   wen     in   write enable; waddr/wdata committed at the clock edge
//   waddr   in   AW  write address
//   wdata   in   DW  write data
//   ren     in   read enable; rdata loads bank[raddr] at the clock edge
//   raddr   in   AW  read address
//   rdata   out  DW  registered read data, held while ren is low
module regbank
   import regarb_defs::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wen,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          ren,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem_r [DEPTH];
   logic [DW-1:0] rdata_r;

   // Storage array; clear wins over a coincident write.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DW{1'b0}};
         end
      end else if (wen) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port; holds its value when not reading.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rdata_r <= {DW{1'b0}};
      end else if (ren) begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: shares one regbank between NREQ requesters. Each grant
// runs IDLE -> ACCESS -> RESP: the winner's request is latched in IDLE, the
// bank is accessed in ACCESS, and a one-hot ack pulses in RESP.
// Configuration macro: REGARB_FIXED_PRIO_EN
//   undefined : round-robin, scan starts at (last_gnt+1) mod NREQ
//   defined   : fixed priority, lowest asserted index always wins
// Ports:
//   clk     in   rising-edge clock
//   reset_n in   synchronous active-low reset (drops any transaction)
//   req     in   NREQ     level requests, held until ack
//   we      in   NREQ     write(1)/read(0) per requester
//   addr    in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//   wdata   in   NREQ*DW  packed write data, requester i at [i*DW +: DW]
//   ack     out  NREQ     one-hot, one-cycle completion pulse
//   rdata   out  DW       read data, valid in the ack cycle of a read
//   gnt_id  out  IDW      id of the current or last granted requester
//   busy    out  1        high in ACCESS and RESP
module regbank_arbiter
   import regarb_defs::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF,
   parameter int IDW  = clog2(NREQ)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    ack,
   output logic [DW-1:0]      rdata,
   output logic [IDW-1:0]     gnt_id,
   output logic               busy
);

   regarb_state_e   state_r, state_s;
   logic [IDW-1:0]  gnt_id_r, gnt_id_s;
   logic [IDW-1:0]  win_s;
   logic            found_s;
   logic            lat_we_r, lat_we_s;
   logic [AW-1:0]   lat_addr_r, lat_addr_s;
   logic [DW-1:0]   lat_wdata_r, lat_wdata_s;
   logic [NREQ-1:0] ack_r, ack_s;
   logic            busy_r, busy_s;
   logic            bank_wen_s, bank_ren_s;
`ifndef REGARB_FIXED_PRIO_EN
   logic [IDW-1:0]  last_gnt_r, last_gnt_s;
`endif

   // Priority picker: first asserted request in scan order. Indices wrap at
   // NREQ, so unused id codes are never produced.
   always_comb begin
      win_s   = {IDW{1'b0}};
      found_s = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
`ifdef REGARB_FIXED_PRIO_EN
         idx = k;
`else
         idx = (int'(last_gnt_r) + 32'sd1 + k) % NREQ;
`endif
         win_s   = (!found_s && req[idx]) ? IDW'(idx) : win_s;
         found_s = found_s | req[idx];
      end
   end

   // Next-state and next-output logic for the grant sequencer.
   always_comb begin
      state_s     = state_r;
      gnt_id_s    = gnt_id_r;
      lat_we_s    = lat_we_r;
      lat_addr_s  = lat_addr_r;
      lat_wdata_s = lat_wdata_r;
      ack_s       = {NREQ{1'b0}};
      busy_s      = busy_r;
`ifndef REGARB_FIXED_PRIO_EN
      last_gnt_s  = last_gnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (found_s) begin
               state_s     = ACCESS;
               gnt_id_s    = win_s;
               lat_we_s    = we[win_s];
               lat_addr_s  = addr[int'(win_s)*AW +: AW];
               lat_wdata_s = wdata[int'(win_s)*DW +: DW];
               busy_s      = 1'b1;
            end else begin
               state_s = IDLE;
               busy_s  = 1'b0;
            end
         end
         ACCESS: begin
            // ack is registered, so it is loaded here to be visible in RESP.
            state_s = RESP;
            ack_s   = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id_r;
         end
         RESP: begin
            state_s = IDLE;
            busy_s  = 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
            last_gnt_s = gnt_id_r;
`endif
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State, latched request and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         gnt_id_r    <= {IDW{1'b0}};
         lat_we_r    <= 1'b0;
         lat_addr_r  <= {AW{1'b0}};
         lat_wdata_r <= {DW{1'b0}};
         ack_r       <= {NREQ{1'b0}};
         busy_r      <= 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
         last_gnt_r  <= IDW'(NREQ - 1);
`endif
      end else begin
         state_r     <= state_s;
         gnt_id_r    <= gnt_id_s;
         lat_we_r    <= lat_we_s;
         lat_addr_r  <= lat_addr_s;
         lat_wdata_r <= lat_wdata_s;
         ack_r       <= ack_s;
         busy_r      <= busy_s;
`ifndef REGARB_FIXED_PRIO_EN
         last_gnt_r  <= last_gnt_s;
`endif
      end
   end

   assign bank_wen_s = (state_r == ACCESS) &&  lat_we_r;
   assign bank_ren_s = (state_r == ACCESS) && !lat_we_r;

   regbank #(
      .AW (AW),
      .DW (DW)
   ) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .wen     (bank_wen_s),
      .waddr   (lat_addr_r),
      .wdata   (lat_wdata_r),
      .ren     (bank_ren_s),
      .raddr   (lat_addr_r),
      .rdata   (rdata)
   );

   assign ack    = ack_r;
   assign gnt_id = gnt_id_r;
   assign busy   = busy_r;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Self-checking bench for regbank_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_regbank_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 3;
   localparam int DW   = 8;
   localparam int IDW  = 2;

   logic               clk     = 1'b0;
   logic               reset_n = 1'b0;
   logic [NREQ-1:0]    req     = '0;
   logic [NREQ-1:0]    we      = '0;
   logic [NREQ*AW-1:0] addr    = '0;
   logic [NREQ*DW-1:0] wdata   = '0;
   logic [NREQ-1:0]    ack;
   logic [DW-1:0]      rdata;
   logic [IDW-1:0]     gnt_id;
   logic               busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regbank_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .ack     (ack),
      .rdata   (rdata),
      .gnt_id  (gnt_id),
      .busy    (busy)
   );

   // ---------------- reference model ----------------
   // Winner = first set request scanning upward from last+1 (round robin)
   // or from 0 (fixed priority), wrapping at NREQ.
   function automatic int pick(input logic [NREQ-1:0] r, input int last);
      int start;
      start = (last + 1) % NREQ;
`ifdef REGARB_FIXED_PRIO_EN
      start = 0;
`endif
      for (int k = 0; k < NREQ; k++) begin
         if (r[(start + k) % NREQ]) return (start + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   logic [DW-1:0]   m_bank [8];
   int              m_last, m_left, m_win, m_pick;
   logic            m_we;
   logic [AW-1:0]   m_a;
   logic [DW-1:0]   m_d;
   logic [NREQ-1:0] exp_ack;
   logic [DW-1:0]   exp_rdata;
   logic [IDW-1:0]  exp_gnt;
   logic            exp_busy;

   always_comb m_pick = pick(req, m_last);

   // Transaction model: grant, then access one cycle later, then ack cycle.
   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) m_bank[i] <= '0;
         m_last <= NREQ - 1; m_left <= 0;
         exp_ack <= '0; exp_rdata <= '0; exp_gnt <= '0; exp_busy <= 1'b0;
      end else if (m_left == 0) begin
         if (req != '0) begin
            m_win <= m_pick; exp_gnt <= IDW'(m_pick); exp_busy <= 1'b1; m_left <= 2;
            m_we <= we[m_pick]; m_a <= addr[m_pick*AW +: AW]; m_d <= wdata[m_pick*DW +: DW];
         end
      end else if (m_left == 2) begin
         if (m_we) m_bank[m_a] <= m_d;
         else      exp_rdata <= m_bank[m_a];
         exp_ack <= onehot(m_win); m_left <= 1;
      end else begin
         m_last <= m_win; exp_ack <= '0; exp_busy <= 1'b0; m_left <= 0;
      end
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      we[i] = w; addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d; req[i] = 1'b1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1; reset_n = 1'b0; req = '0;
      repeat (2) @(posedge clk);
      #1; reset_n = 1'b1;
   endtask

   // Drives one request just after an edge and waits (bounded) for any ack.
   task automatic run_single(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output int lat, output logic [NREQ-1:0] ackv, output logic [DW-1:0] rd);
      @(posedge clk); #1; set_req(i, w, a, d);
      lat = -1; ackv = '0; rd = '0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (ack != '0) begin lat = n; ackv = ack; rd = rdata; break; end
      end
      req[i] = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0; req = 4'b1111;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b expected 0000", ack); end
      n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
      n_vec++; if (gnt_id !== 2'd0) begin n_err++; $display("FAIL reset_gnt: got %0d expected 0", gnt_id); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      req = '0;
      @(posedge clk); #1; reset_n = 1'b1;
   endtask

   task automatic test_write_read();
      int lat; logic [NREQ-1:0] av; logic [DW-1:0] rd;
      run_single(0, 1'b1, 3'd3, 8'hA5, lat, av, rd);
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL wr_latency: got %0d expected 3", lat); end
      n_vec++; if (av !== 4'b0001) begin n_err++; $display("FAIL wr_ack: got %b expected 0001", av); end
      run_single(0, 1'b0, 3'd3, 8'h00, lat, av, rd);
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL rd_latency: got %0d expected 3", lat); end
      n_vec++; if (av !== 4'b0001) begin n_err++; $display("FAIL rd_ack: got %b expected 0001", av); end
      n_vec++; if (rd !== 8'hA5) begin n_err++; $display("FAIL rd_data: got %h expected a5", rd); end
      n_vec++; if (gnt_id !== 2'd0) begin n_err++; $display("FAIL rd_gnt: got %0d expected 0", gnt_id); end
   endtask

   task automatic test_drop_in_access();
      int lat; logic [NREQ-1:0] av; logic [DW-1:0] rd;
      @(posedge clk); #1; set_req(1, 1'b1, 3'd5, 8'h3C);
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle_busy: got %b expected 0", busy); end
      @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL drop_access_busy: got %b expected 1", busy); end
      n_vec++; if (gnt_id !== 2'd1) begin n_err++; $display("FAIL drop_gnt: got %0d expected 1", gnt_id); end
      // Drop the request and scramble its fields; the latched copy must win.
      req[1] = 1'b0; we[1] = 1'b0; addr[1*AW +: AW] = 3'd0; wdata[1*DW +: DW] = 8'h00;
      @(negedge clk);
      n_vec++; if (ack !== 4'b0010) begin n_err++; $display("FAIL drop_ack: got %b expected 0010", ack); end
      n_vec++; if (rdata !== 8'hA5) begin n_err++; $display("FAIL write_keeps_rdata: got %h expected a5", rdata); end
      run_single(2, 1'b0, 3'd5, 8'h00, lat, av, rd);
      n_vec++; if (av !== 4'b0100) begin n_err++; $display("FAIL drop_rd_ack: got %b expected 0100", av); end
      n_vec++; if (rd !== 8'h3C) begin n_err++; $display("FAIL drop_rd_data: got %h expected 3c", rd); end
   endtask

   task automatic test_reset_in_flight();
      int lat; logic [NREQ-1:0] av; logic [DW-1:0] rd; int seen;
      run_single(0, 1'b1, 3'd7, 8'hFF, lat, av, rd);
      n_vec++; if (av !== 4'b0001) begin n_err++; $display("FAIL rif_first_ack: got %b expected 0001", av); end
      @(posedge clk); #1; set_req(3, 1'b1, 3'd7, 8'h11);
      @(negedge clk); @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rif_access_busy: got %b expected 1", busy); end
      reset_n = 1'b0; req = '0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         n_vec++; if (ack !== 4'b0000 || busy !== 1'b0 || rdata !== 8'h00) begin
            n_err++; $display("FAIL rif_dropped: got ack=%b busy=%b rdata=%h expected 0000/0/00", ack, busy, rdata);
         end
      end
      @(posedge clk); #1; reset_n = 1'b1;
      set_req(0, 1'b0, 3'd7, 8'h00); set_req(3, 1'b0, 3'd7, 8'h00);
      for (int k = 0; k < 2; k++) begin
         seen = 0;
         for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (ack != '0) begin seen = 1; break; end
         end
         n_vec++; if (seen !== 1) begin n_err++; $display("FAIL rif_timeout: got no ack expected ack %0d", k); end
         n_vec++; if (ack !== (k == 0 ? 4'b0001 : 4'b1000)) begin
            n_err++; $display("FAIL rif_order: got %b expected %b", ack, (k == 0 ? 4'b0001 : 4'b1000));
         end
         n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL rif_cleared: got %h expected 00", rdata); end
         req[k == 0 ? 0 : 3] = 1'b0;
      end
   endtask

   task automatic test_rotation(input logic [NREQ-1:0] pattern);
      int prev, last_n, got, eid;
      @(posedge clk); #1; reset_n = 1'b0; req = pattern; we = '0; addr = NREQ*AW'($urandom);
      repeat (2) @(posedge clk);
      #1; reset_n = 1'b1;
      prev = NREQ - 1; last_n = 0; got = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (ack != '0) begin
            eid = pick(pattern, prev);
            n_vec++; if (ack !== onehot(eid)) begin n_err++; $display("FAIL rot_ack: got %b expected %b", ack, onehot(eid)); end
            n_vec++; if (gnt_id !== IDW'(eid)) begin n_err++; $display("FAIL rot_gnt: got %0d expected %0d", gnt_id, eid); end
            n_vec++; if (n - last_n !== 3) begin n_err++; $display("FAIL rot_spacing: got %0d expected 3", n - last_n); end
            prev = eid; last_n = n; got++;
            if (got == 5) begin req = '0; break; end
         end
      end
      n_vec++; if (got !== 5) begin n_err++; $display("FAIL rot_count: got %0d expected 5", got); end
      req = '0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_back_to_back();
      int t1, t2;
      t1 = -1; t2 = -1;
      @(posedge clk); #1; set_req(0, 1'b0, 3'd3, 8'h00);
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (t1 >= 0 && n == t1 + 1) begin
            n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL b2b_pulse: got %b expected 0000", ack); end
         end
         if (ack != '0) begin
            if (t1 < 0) t1 = n;
            else begin t2 = n; break; end
         end
      end
      req[0] = 1'b0;
      n_vec++; if (t1 !== 3) begin n_err++; $display("FAIL b2b_first: got %0d expected 3", t1); end
      n_vec++; if (t2 - t1 !== 3) begin n_err++; $display("FAIL b2b_second: got %0d expected 3", t2 - t1); end
      n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL b2b_ack: got %b expected 0001", ack); end
      n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL b2b_rdata: got %h expected 00", rdata); end
   endtask

   task automatic test_random();
      int acks;
      acks = 0;
      do_reset();
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         n_vec++; if (ack !== exp_ack) begin n_err++; $display("FAIL rnd_ack@%0d: got %b expected %b", c, ack, exp_ack); end
         n_vec++; if (gnt_id !== exp_gnt) begin n_err++; $display("FAIL rnd_gnt@%0d: got %0d expected %0d", c, gnt_id, exp_gnt); end
         n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL rnd_busy@%0d: got %b expected %b", c, busy, exp_busy); end
         n_vec++; if (rdata !== exp_rdata) begin n_err++; $display("FAIL rnd_rdata@%0d: got %h expected %h", c, rdata, exp_rdata); end
         if (ack != '0) acks++;
         for (int i = 0; i < NREQ; i++) begin
            if (req[i] && ack[i]) req[i] = 1'b0;
            else if (!req[i] && $urandom_range(0, 3) == 0)
               set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
         end
      end
      n_vec++; if (acks < 20) begin n_err++; $display("FAIL rnd_activity: got %0d acks expected at least 20", acks); end
      req = '0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_drop_in_access();
      test_reset_in_flight();
      test_rotation(4'b1111);
      test_rotation(4'b0101);
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
